// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO in front of it.
// The frame format (8 baud rates, parity, 1/2 stop bits) is latched when each word is popped.
module uart_tx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLK_HZ     = 50_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             Tx_DATA,
    input  logic                          Tx_WR,
    input  logic                          TX_EN,
    input  logic [2:0]                    baud_select,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
    input  logic                          ovf_clr,
    output logic                          TxD,
    output logic                          Tx_BUSY,
    output logic                          Tx_FULL,
    output logic                          Tx_EMPTY,
    output logic [$clog2(FIFO_DEPTH):0]   Tx_LEVEL,
    output logic                          Tx_OVF
);
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W     = PTR_W + 1;
    localparam int unsigned BIT_W     = 4;
    localparam int unsigned BC_300    = (CLK_HZ + 150) / 300;
    localparam int unsigned BC_1200   = (CLK_HZ + 600) / 1200;
    localparam int unsigned BC_4800   = (CLK_HZ + 2400) / 4800;
    localparam int unsigned BC_9600   = (CLK_HZ + 4800) / 9600;
    localparam int unsigned BC_19200  = (CLK_HZ + 9600) / 19200;
    localparam int unsigned BC_38400  = (CLK_HZ + 19200) / 38400;
    localparam int unsigned BC_57600  = (CLK_HZ + 28800) / 57600;
    localparam int unsigned BC_115200 = (CLK_HZ + 57600) / 115200;
    localparam int unsigned CNT_W     = $clog2(BC_300 + 1);

    if (BC_115200 < 2) begin : g_chk_clk
        $error("uart_tx_fifo: CLK_HZ too low, bit period below 2 clocks");
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_chk_dw
        $error("uart_tx_fifo: DATA_W must be 5..9");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (1 << PTR_W) != FIFO_DEPTH) begin : g_chk_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two in 2..64");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    // Terminal count (bit period minus one) for each baud_select code.
    function automatic logic [CNT_W-1:0] last_cnt(input logic [2:0] sel);
        case (sel)
            3'd0:    last_cnt = CNT_W'(BC_300 - 1);
            3'd1:    last_cnt = CNT_W'(BC_1200 - 1);
            3'd2:    last_cnt = CNT_W'(BC_4800 - 1);
            3'd3:    last_cnt = CNT_W'(BC_9600 - 1);
            3'd4:    last_cnt = CNT_W'(BC_19200 - 1);
            3'd5:    last_cnt = CNT_W'(BC_38400 - 1);
            3'd6:    last_cnt = CNT_W'(BC_57600 - 1);
            default: last_cnt = CNT_W'(BC_115200 - 1);
        endcase
    endfunction

    state_e              state_q, state_d;
    logic                txd_q, txd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    last_q, last_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shr_q, shr_d;
    logic                par_en_q, par_en_d;
    logic                par_bit_q, par_bit_d;
    logic                stop2_q, stop2_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   head;
    logic                bit_done;
    logic                wr_acc;
    logic                frame_start;

    assign head     = mem_q[rd_ptr_q];
    assign bit_done = (cnt_q == last_q);
    assign wr_acc   = Tx_WR && (level_q != LVL_W'(FIFO_DEPTH));

    // Frame sequencer plus FIFO bookkeeping.
    always_comb begin
        state_d     = state_q;
        txd_d       = txd_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        bit_d       = bit_q;
        shr_d       = shr_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        frame_start = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (TX_EN && level_q != '0) frame_start = 1'b1;
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                    txd_d   = shr_q[0];
                    shr_d   = shr_q >> 1;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                        txd_d   = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        txd_d = shr_q[0];
                        shr_d = shr_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (stop2_q && bit_q == '0) begin
                        bit_d = BIT_W'(1);
                    end else if (TX_EN && level_q != '0) begin
                        frame_start = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pop the head and freeze the frame configuration for its whole duration.
        if (frame_start) begin
            state_d  = S_START;
            txd_d    = 1'b0;
            cnt_d    = '0;
            last_d   = last_cnt(baud_select);
            shr_d    = head;
            par_en_d = (parity_mode != 2'b00);
            stop2_d  = stop2;
            case (parity_mode)
                2'b01:   par_bit_d = ^head;
                2'b10:   par_bit_d = ~^head;
                2'b11:   par_bit_d = 1'b1;
                default: par_bit_d = 1'b0;
            endcase
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
        rd_ptr_d = rd_ptr_q + PTR_W'(frame_start);
        level_d  = level_q + LVL_W'(wr_acc) - LVL_W'(frame_start);
        ovf_d    = (Tx_WR && !wr_acc) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        busy_d   = (state_d != S_IDLE) || (level_d != '0);
        full_d   = (level_d == LVL_W'(FIFO_DEPTH));
        empty_d  = (level_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            txd_q     <= 1'b1;
            cnt_q     <= '0;
            last_q    <= '0;
            bit_q     <= '0;
            shr_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            txd_q     <= txd_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            bit_q     <= bit_d;
            shr_q     <= shr_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= Tx_DATA;
    end

    assign TxD      = txd_q;
    assign Tx_BUSY  = busy_q;
    assign Tx_FULL  = full_q;
    assign Tx_EMPTY = empty_q;
    assign Tx_LEVEL = level_q;
    assign Tx_OVF   = ovf_q;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, 2..64.
REQ-003 Parameter CLK_HZ, default 50_000_000, clock frequency in Hz used to derive bit periods.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 Tx_DATA  in  DATA_W  word to enqueue.
REQ-007 Tx_WR  in  1  write strobe; one word enqueued per cycle high.
REQ-008 TX_EN  in  1  transmit enable; gates frame starts only.
REQ-009 baud_select  in  3  rate: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200 baud.
REQ-010 parity_mode  in  2  00=none, 01=even, 10=odd, 11=mark (constant 1).
REQ-011 stop2  in  1  0=one stop bit, 1=two stop bits.
REQ-012 ovf_clr  in  1  clears Tx_OVF.
REQ-013 TxD  out  1  serial line, idle high.
REQ-014 Tx_BUSY  out  1  high while a frame is on the line or the FIFO is non-empty.
REQ-015 Tx_FULL / Tx_EMPTY  out  1 each  FIFO status, from the registered count.
REQ-016 Tx_LEVEL  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-017 Tx_OVF  out  1  sticky overflow flag.

Function
REQ-018 Bit period = BIT_CYC = round(CLK_HZ/baud) clocks.
  - Computed at elaboration for all 8 rates.
  - BIT_CYC < 2 is an elaboration error.
REQ-019 Frame order: start (0), DATA_W data bits LSB first, optional parity bit, 1 or 2 stop bits (1).
  - Every bit lasts exactly BIT_CYC cycles.
REQ-020 FSM states IDLE, START, DATA, PARITY, STOP.
  - IDLE->START: TX_EN=1 and FIFO non-empty at an edge; pop head and latch word, baud_select, parity_mode, stop2 at that edge.
  - START->DATA: after BIT_CYC cycles.
  - DATA->PARITY: after DATA_W bits when parity_mode != none; else DATA->STOP.
  - PARITY->STOP: after BIT_CYC cycles.
  - STOP->IDLE: after 1 or 2 stop bit periods.
REQ-021 Back-to-back frames: FIFO non-empty and TX_EN=1 at end of STOP -> go directly to START with no idle gap.
REQ-022 Latency: TxD is registered and falls at the edge that pops the word.
  - Word written at edge N into an empty FIFO while IDLE with TX_EN=1 -> TxD low from edge N+1.
REQ-023 Config changes mid-frame have no effect; the latched values apply until STOP completes.
REQ-024 Parity: even = XOR of data bits; odd = its inverse; mark = 1.
REQ-025 TX_EN deasserted mid-frame: current frame completes, then FSM stays in IDLE with FIFO contents retained.
REQ-026 Write with FIFO not full: word accepted; Tx_LEVEL +1 next cycle.
REQ-027 Write while full: word discarded, Tx_OVF set next cycle.
  - Applies even if a pop occurs in the same cycle (full judged on the pre-edge count).
REQ-028 Simultaneous accepted write and pop: Tx_LEVEL unchanged.
REQ-029 Write to an empty FIFO never bypasses the FIFO.
REQ-030 Tx_OVF clears on ovf_clr=1; a set condition in the same cycle wins.
REQ-031 FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-032 reset=0 forces immediately, independent of clk:
  - TxD=1, FSM=IDLE, FIFO empty (Tx_LEVEL=0, Tx_EMPTY=1, Tx_FULL=0).
  - Tx_BUSY=0, Tx_OVF=0, baud counter and bit counter cleared.
REQ-033 Reset asserted mid-frame aborts the frame with TxD high; no partial frame resumes after release.
REQ-034 First frame may start on the first rising edge after reset deasserts.

Verification (CLK_HZ=1_152_000, DATA_W=8, FIFO_DEPTH=4)
REQ-035 baud_select=111, parity none, stop2=0, TX_EN=1, write 0x55 -> TxD = 0,1,0,1,0,1,0,1,0,1, each 10 cycles; Tx_BUSY falls after 100 cycles.
REQ-036 parity_mode=01, write 0x07 -> parity bit 1; parity_mode=10, write 0x07 -> parity bit 0; stop2=1 -> stop high for 20 cycles.
REQ-037 TX_EN=0, write 0xA1, 0xB2, 0xC3, 0xD4, 0xE5 -> Tx_FULL=1, Tx_LEVEL=4, Tx_OVF=1, TxD stays 1; set TX_EN=1 -> frames A1, B2, C3, D4 back-to-back with no gap; E5 never sent.
REQ-038 baud_select changed 111->110 mid-frame -> current frame keeps 10-cycle bits; next frame uses 20-cycle bits.
REQ-039 reset pulsed low during DATA of 0x3C -> TxD=1 at once, Tx_LEVEL=0; no further frame without a new write.
REQ-040 DATA_W=5 instance, write 5'h13 -> 5 data bits LSB first, frame length 7 bit periods (no parity, 1 stop).
